imm_encoder: RTL and testbench

- Inverse of the core immediate-generation path. Takes a 4-bit opcode and a desired 16-bit immediate value, and produces the 8-bit instruction immediate field that the decoder expands back to exactly that value.
- Reports when the value is not encodable: it is odd where a shift is required, or it is out of range for the field width.
- Sits in the debug/instruction-injection path, feeding instruction builders, behind a 2-stage valid/ready pipeline.

---
 rtl/imm_encoder_pkg.sv | 50 +++++
 rtl/imm_encoder_if.sv | 26 ++
 rtl/imm_fmt_classify.sv | 13 +
 rtl/imm_encoder.sv | 118 +++++++++++
 tb/tb_imm_encoder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_encoder_pkg.sv
// Immediate-format definitions shared by the immediate encoder and generator.
package imm_encoder_pkg;

    typedef enum logic [1:0] {
        IMM_FMT_5 = 2'd0,
        IMM_FMT_6 = 2'd1,
        IMM_FMT_8 = 2'd2
    } immFmt_t;

    localparam int unsigned IMM_W5 = 5;
    localparam int unsigned IMM_W6 = 6;
    localparam int unsigned IMM_W8 = 8;

    localparam logic [7:0] IMM_MASK5 = 8'h1F;
    localparam logic [7:0] IMM_MASK6 = 8'h3F;
    localparam logic [7:0] IMM_MASK8 = 8'hFF;

    // 0b0X0X -> 6-bit, 0bX010 -> 8-bit, everything else 5-bit.
    function automatic immFmt_t opcodeToFmt(input logic [3:0] opcode);
        if (!opcode[3] && !opcode[1]) begin
            return IMM_FMT_6;
        end else if (opcode[2:0] == 3'b010) begin
            return IMM_FMT_8;
        end else begin
            return IMM_FMT_5;
        end
    endfunction

    // Opcodes in the lower half store the immediate pre-shifted by one.
    function automatic logic opcodeToShift(input logic [3:0] opcode);
        return ~opcode[3];
    endfunction

    function automatic int unsigned fmtWidth(input immFmt_t fmt);
        case (fmt)
            IMM_FMT_6: return IMM_W6;
            IMM_FMT_8: return IMM_W8;
            default:   return IMM_W5;
        endcase
    endfunction

    function automatic logic [7:0] fmtMask(input immFmt_t fmt);
        case (fmt)
            IMM_FMT_6: return IMM_MASK6;
            IMM_FMT_8: return IMM_MASK8;
            default:   return IMM_MASK5;
        endcase
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result handshake bundle of the immediate encoder.
interface imm_encoder_if;

    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_opcode;
    logic [15:0] i_value;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_immSrc;
    logic [7:0]  o_mask;
    logic        o_fits;
    logic        o_errOdd;
    logic        o_errRange;

    modport master (
        output i_valid, i_opcode, i_value, i_ready,
        input  o_ready, o_valid, o_immSrc, o_mask, o_fits, o_errOdd, o_errRange
    );

    modport slave (
        input  i_valid, i_opcode, i_value, i_ready,
        output o_ready, o_valid, o_immSrc, o_mask, o_fits, o_errOdd, o_errRange
    );

endinterface

// File: rtl/imm_fmt_classify.sv
// Opcode to immediate format and shift flag, built on the shared package helpers.
module imm_fmt_classify
    import imm_encoder_pkg::*;
(
    input  logic [3:0] opcode,
    output immFmt_t    fmt,
    output logic       shift
);

    assign fmt   = opcodeToFmt(opcode);
    assign shift = opcodeToShift(opcode);

endmodule

// File: rtl/imm_encoder.sv
// Two-stage encoder: desired immediate value -> instruction immediate field,
// with encodability flags and a saturating count of rejected results.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    imm_encoder_if.slave     bus,
    input  logic             i_clrCnt,
    output logic [CNT_W-1:0] o_rejectCnt
);

    logic        s1Valid;
    logic [3:0]  s1Opcode;
    logic [15:0] s1Value;
    logic        s2Valid;
    logic        advance;

    immFmt_t     fmt;
    logic        shift;

    logic [15:0] unshifted;
    int unsigned width;
    logic [7:0]  encImm;
    logic [7:0]  encMask;
    logic        encOdd;
    logic        encRange;

    logic [7:0]  immSrc;
    logic [7:0]  mask;
    logic        fits;
    logic        errOdd;
    logic        errRange;
    logic [CNT_W-1:0] rejectCnt;

    // Stage 2 moves when it is empty or its result is being taken.
    assign advance     = ~s2Valid | bus.i_ready;
    assign bus.o_ready = ~s1Valid | advance;
    assign bus.o_valid = s2Valid;

    imm_fmt_classify classify (
        .opcode (s1Opcode),
        .fmt    (fmt),
        .shift  (shift)
    );

    // Stage 1 register: capture a request whenever the slot is free or moving on.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1Valid  <= 1'b0;
            s1Opcode <= '0;
            s1Value  <= '0;
        end else if (bus.o_ready) begin
            s1Valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1Opcode <= bus.i_opcode;
                s1Value  <= bus.i_value;
            end
        end
    end

    // Encode: unshift, check the remaining upper bits are a pure sign extension, truncate.
    always_comb begin
        unshifted = shift ? {s1Value[15], s1Value[15:1]} : s1Value;
        width     = fmtWidth(fmt);
        encMask   = fmtMask(fmt);
        encOdd    = shift & s1Value[0];
        encRange  = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if ((i + 1 >= width) && (unshifted[i] != unshifted[15])) begin
                encRange = 1'b1;
            end
        end
        encImm = unshifted[7:0] & encMask;
    end

    // Stage 2 register: result slot, held while downstream stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2Valid  <= 1'b0;
            immSrc   <= '0;
            mask     <= '0;
            fits     <= 1'b0;
            errOdd   <= 1'b0;
            errRange <= 1'b0;
        end else if (advance) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                immSrc   <= encImm;
                mask     <= encMask;
                fits     <= ~encOdd & ~encRange;
                errOdd   <= encOdd;
                errRange <= encRange;
            end
        end
    end

    // Reject counter: saturating count of non-fitting results handed off; clear has priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rejectCnt <= '0;
        end else if (i_clrCnt) begin
            rejectCnt <= '0;
        end else if (s2Valid && bus.i_ready && !fits && (rejectCnt != '1)) begin
            rejectCnt <= rejectCnt + CNT_W'(1);
        end
    end

    assign bus.o_immSrc   = immSrc;
    assign bus.o_mask     = mask;
    assign bus.o_fits     = fits;
    assign bus.o_errOdd   = errOdd;
    assign bus.o_errRange = errRange;
    assign o_rejectCnt    = rejectCnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: vector table, backpressure, counter and reset sequences.
module tb_imm_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       clrCnt;
    logic [7:0] rejectCnt;

    imm_encoder_if bus();

    imm_encoder #(.CNT_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .i_clrCnt    (clrCnt),
        .o_rejectCnt (rejectCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] val;
        logic [7:0]  imm;
        logic [7:0]  mask;
        logic        fits;
        logic        odd;
        logic        range;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    int nCompared   = 0;
    int nMismatched = 0;
    int expReject   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResult(input string tag, input vec_t v);
        check({tag, ".immSrc"},   bus.o_immSrc,   v.imm);
        check({tag, ".mask"},     bus.o_mask,     v.mask);
        check({tag, ".fits"},     bus.o_fits,     v.fits);
        check({tag, ".errOdd"},   bus.o_errOdd,   v.odd);
        check({tag, ".errRange"}, bus.o_errRange, v.range);
    endtask

    // Present one request and hold it until the handshake edge has passed.
    task automatic sendReq(input logic [3:0] op, input logic [15:0] val);
        @(negedge clk);
        bus.i_valid  = 1'b1;
        bus.i_opcode = op;
        bus.i_value  = val;
        for (int k = 0; k < 20 && !bus.o_ready; k++) @(negedge clk);
        if (!bus.o_ready) begin
            check("handshake_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        bus.i_valid  = 1'b0;
        bus.i_opcode = 4'hF;
        bus.i_value  = 16'hDEAD;
    endtask

    // Stop at the first negedge showing o_valid, within a bounded number of cycles.
    task automatic waitValid(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.o_valid) begin
                ok = 1'b1;
                return;
            end
        end
        check("valid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          bpIdx[4];
        int          sent, recv, firstHs, firstValid, nHs;
        bit          prevStall, sawBlocked;
        logic [7:0]  hImm, hMask;
        logic        hFits, hOdd, hRange;

        vecs[0]  = '{4'h2, 16'h00FE, 8'h7F, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'h2, 16'hFF00, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'h2, 16'h0100, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{4'hA, 16'hFFFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'hA, 16'h0080, 8'h80, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{4'hA, 16'h007F, 8'h7F, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'h4, 16'h0003, 8'h01, 8'h3F, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'h4, 16'h003E, 8'h1F, 8'h3F, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'h4, 16'h0040, 8'h20, 8'h3F, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{4'h4, 16'hFFC0, 8'h20, 8'h3F, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'h8, 16'hFFF0, 8'h10, 8'h1F, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'h8, 16'h0010, 8'h10, 8'h1F, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{4'h3, 16'h001E, 8'h0F, 8'h1F, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'h0, 16'h0001, 8'h00, 8'h3F, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{4'h5, 16'hFFFF, 8'h3F, 8'h3F, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{4'h4, 16'h0081, 8'h00, 8'h3F, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{4'hA, 16'hFF80, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{4'h6, 16'hFFE0, 8'h10, 8'h1F, 1'b1, 1'b0, 1'b0};

        bus.i_valid  = 1'b0;
        bus.i_opcode = 4'h0;
        bus.i_value  = 16'h0000;
        bus.i_ready  = 1'b1;
        clrCnt       = 1'b0;
        rst          = 1'b1;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst.o_valid",    bus.o_valid,    1'b0);
        check("rst.immSrc",     bus.o_immSrc,   8'h00);
        check("rst.mask",       bus.o_mask,     8'h00);
        check("rst.fits",       bus.o_fits,     1'b0);
        check("rst.errOdd",     bus.o_errOdd,   1'b0);
        check("rst.errRange",   bus.o_errRange, 1'b0);
        check("rst.rejectCnt",  rejectCnt,      8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.o_ready", bus.o_ready, 1'b1);

        // Table-driven single requests.
        for (int i = 0; i < NVEC; i++) begin
            sendReq(vecs[i].op, vecs[i].val);
            waitValid(ok);
            if (ok) begin
                checkResult($sformatf("vec%0d", i), vecs[i]);
                if (!vecs[i].fits) expReject++;
            end
        end
        @(negedge clk);
        check("table.rejectCnt", rejectCnt, expReject);

        // Backpressure: four back-to-back requests, downstream stalled in cycles 2..4.
        bpIdx      = '{0, 2, 6, 9};
        sent       = 0;
        recv       = 0;
        firstHs    = -1;
        firstValid = -1;
        prevStall  = 1'b0;
        sawBlocked = 1'b0;
        hImm = '0; hMask = '0; hFits = 1'b0; hOdd = 1'b0; hRange = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (prevStall) begin
                check("bp.hold.o_valid",  bus.o_valid,    1'b1);
                check("bp.hold.immSrc",   bus.o_immSrc,   hImm);
                check("bp.hold.mask",     bus.o_mask,     hMask);
                check("bp.hold.fits",     bus.o_fits,     hFits);
                check("bp.hold.errOdd",   bus.o_errOdd,   hOdd);
                check("bp.hold.errRange", bus.o_errRange, hRange);
            end
            if (bus.o_valid && firstValid < 0) firstValid = c;
            bus.i_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            if (sent < 4) begin
                bus.i_valid  = 1'b1;
                bus.i_opcode = vecs[bpIdx[sent]].op;
                bus.i_value  = vecs[bpIdx[sent]].val;
            end else begin
                bus.i_valid = 1'b0;
            end
            #1;
            check($sformatf("bp.o_ready.c%0d", c), bus.o_ready,
                  !(((sent - recv) == 2) && !bus.i_ready));
            if (!bus.o_ready) sawBlocked = 1'b1;
            if (bus.o_valid && bus.i_ready) begin
                if (recv < 4) begin
                    checkResult($sformatf("bp.out%0d", recv), vecs[bpIdx[recv]]);
                    if (!vecs[bpIdx[recv]].fits) expReject++;
                end else begin
                    check("bp.extra_result", 32'd1, 32'd0);
                end
                recv++;
            end
            prevStall = bus.o_valid && !bus.i_ready;
            if (prevStall) begin
                hImm   = bus.o_immSrc;
                hMask  = bus.o_mask;
                hFits  = bus.o_fits;
                hOdd   = bus.o_errOdd;
                hRange = bus.o_errRange;
            end
            if (bus.i_valid && bus.o_ready) begin
                if (firstHs < 0) firstHs = c;
                sent++;
            end
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        check("bp.received",   recv, 4);
        check("bp.latency",    firstValid - firstHs, 2);
        check("bp.readyDrop",  sawBlocked, 1'b1);
        @(negedge clk);
        check("bp.rejectCnt",  rejectCnt, expReject);

        // Saturation: clear, then 260 rejected results.
        clrCnt = 1'b1;
        @(negedge clk);
        clrCnt = 1'b0;
        check("clr.rejectCnt", rejectCnt, 8'd0);
        bus.i_valid  = 1'b1;
        bus.i_opcode = 4'h2;
        bus.i_value  = 16'h0100;
        nHs = 0;
        for (int k = 0; k < 300 && nHs < 260; k++) begin
            if (bus.o_ready) nHs++;
            @(negedge clk);
        end
        bus.i_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("sat.handshakes", nHs, 260);
        check("sat.rejectCnt",  rejectCnt, 8'd255);

        // Clear coinciding with a reject transfer.
        clrCnt = 1'b1;
        @(negedge clk);
        clrCnt = 1'b0;
        sendReq(4'h2, 16'h0100);
        waitValid(ok);
        @(negedge clk);
        check("coin.pre.rejectCnt", rejectCnt, 8'd1);
        sendReq(4'h8, 16'h0010);
        waitValid(ok);
        check("coin.fits", bus.o_fits, 1'b0);
        clrCnt = 1'b1;
        @(negedge clk);
        clrCnt = 1'b0;
        check("coin.rejectCnt", rejectCnt, 8'd0);

        // Asynchronous reset with both stages full.
        sendReq(4'h4, 16'h0003);
        waitValid(ok);
        @(negedge clk);
        check("prerst.rejectCnt", rejectCnt, 8'd1);
        bus.i_ready = 1'b0;
        sendReq(4'h2, 16'h00FE);
        sendReq(4'hA, 16'h007F);
        @(negedge clk);
        check("full.o_ready", bus.o_ready, 1'b0);
        check("full.o_valid", bus.o_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.o_valid",   bus.o_valid,    1'b0);
        check("arst.immSrc",    bus.o_immSrc,   8'h00);
        check("arst.mask",      bus.o_mask,     8'h00);
        check("arst.fits",      bus.o_fits,     1'b0);
        check("arst.rejectCnt", rejectCnt,      8'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        check("postrst.o_ready",   bus.o_ready, 1'b1);
        check("postrst.rejectCnt", rejectCnt,   8'd0);
        repeat (4) begin
            @(negedge clk);
            check("postrst.o_valid", bus.o_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
